// File: rtl/data_mem_seq.sv
// Parametrised single-port data memory with registered read port,
// write-first forwarding and a hardware clear sequencer.
module data_mem_seq #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] DataAddress,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  input  logic          ClearReq,
  output logic [DW-1:0] DataOut,
  output logic          ReadValid,
  output logic          Busy,
  output logic          Collision
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [DW-1:0] core [DEPTH];

  logic clr_we;
  logic acc_rd;
  logic acc_wr;
  logic clr_acc;
  logic last;

  assign Busy = (state == CLEAR);
  assign last = (ptr == {AW{1'b1}});

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_we    = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    clr_acc   = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        ptr_nxt = ptr + AW'(1);
        if (last) state_nxt = IDLE;
      end
      IDLE: begin
        acc_rd  = ReadMem;
        clr_acc = ClearReq;
        // a clear request wins over a same-cycle write
        acc_wr  = WriteMem & ~ClearReq;
        if (ClearReq) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      DataOut   <= '0;
      ReadValid <= 1'b0;
      Collision <= 1'b0;
    end else begin
      ReadValid <= acc_rd;
      if (acc_rd) begin
        DataOut <= acc_wr ? DataIn : core[DataAddress];
      end
      if (clr_acc) begin
        Collision <= 1'b0;
      end else if (Busy && (ReadMem || WriteMem)) begin
        Collision <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      if (clr_we) begin
        core[ptr] <= CLEAR_VAL;
      end else if (acc_wr) begin
        core[DataAddress] <= DataIn;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_seq.sv
// Scoreboard bench for data_mem_seq: directed vectors,
// expected read data queued at issue and checked by a monitor.
module tb_data_mem_seq;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic       ClearReq;
  logic [7:0] DataOut;
  logic       ReadValid;
  logic       Busy;
  logic       Collision;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] expq [$];

  data_mem_seq #(.DW(8), .AW(8), .CLEAR_VAL(8'h00)) dut (
    .CLK(CLK),
    .reset(reset),
    .DataAddress(DataAddress),
    .ReadMem(ReadMem),
    .WriteMem(WriteMem),
    .DataIn(DataIn),
    .ClearReq(ClearReq),
    .DataOut(DataOut),
    .ReadValid(ReadValid),
    .Busy(Busy),
    .Collision(Collision)
  );

  always #5 CLK = ~CLK;

  // monitor: every ReadValid must match the oldest queued expectation
  always @(negedge CLK) begin
    if (ReadValid) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read_valid: got DataOut=%02h busy=%0b, none expected",
                 DataOut, Busy);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (DataOut !== e) begin
          miscompares++;
          $display("FAIL read_data: got %02h, expected %02h", DataOut, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    DataAddress = a;
    DataIn = d;
    WriteMem = 1'b1;
    cyc();
    WriteMem = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    DataAddress = a;
    ReadMem = 1'b1;
    expq.push_back(e);
    cyc();
    ReadMem = 1'b0;
  endtask

  // counts edges until Busy drops; also reports any output activity
  task automatic wait_idle(output int n, output logic quiet,
                           output logic coll_low);
    n = 0;
    quiet = 1'b1;
    coll_low = 1'b0;
    do begin
      if (ReadValid) quiet = 1'b0;
      if (!Collision) coll_low = 1'b1;
      cyc();
      n++;
    end while (Busy && n < 400);
  endtask

  int   n;
  logic quiet;
  logic coll_low;

  initial begin
    reset = 1'b0;
    DataAddress = '0;
    ReadMem = 1'b0;
    WriteMem = 1'b0;
    DataIn = '0;
    ClearReq = 1'b0;

    repeat (3) cyc();
    check("reset_busy", Busy, 1);
    check("reset_dataout", DataOut, 8'h00);
    check("reset_valid", ReadValid, 0);
    check("reset_collision", Collision, 0);

    reset = 1'b1;
    n = 0;
    quiet = 1'b1;
    do begin
      if (ReadValid || DataOut !== 8'h00) quiet = 1'b0;
      cyc();
      n++;
    end while (Busy && n < 400);
    check("clear_len_after_reset", n, 256);
    check("clear_outputs_quiet", quiet, 1);

    rd(8'h00, 8'h00);
    rd(8'h7F, 8'h00);
    rd(8'hFF, 8'h00);

    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5);
    cyc();
    check("valid_drops", ReadValid, 0);
    check("dataout_holds", DataOut, 8'hA5);

    wr(8'h20, 8'h11);
    DataIn = 8'h3C;
    WriteMem = 1'b1;
    rd(8'h20, 8'h3C);
    WriteMem = 1'b0;
    rd(8'h20, 8'h3C);

    wr(8'h30, 8'h01);
    wr(8'h31, 8'h02);
    rd(8'h30, 8'h01);
    rd(8'h31, 8'h02);
    rd(8'h10, 8'hA5);

    // access while busy
    ClearReq = 1'b1;
    cyc();
    ClearReq = 1'b0;
    check("clearreq_busy", Busy, 1);
    repeat (9) cyc();
    DataAddress = 8'h05;
    DataIn = 8'h55;
    WriteMem = 1'b1;
    cyc();
    WriteMem = 1'b0;
    check("collision_set", Collision, 1);
    DataAddress = 8'h06;
    ReadMem = 1'b1;
    cyc();
    ReadMem = 1'b0;
    wait_idle(n, quiet, coll_low);
    check("busy_no_valid", quiet, 1);
    check("collision_sticky", coll_low, 0);
    check("clear_len_after_req", n, 256 - 11);
    rd(8'h05, 8'h00);
    rd(8'h10, 8'h00);

    // ClearReq with a dropped same-cycle write
    wr(8'h00, 8'hFF);
    wr(8'h01, 8'hFF);
    wr(8'h02, 8'hFF);
    wr(8'h03, 8'hFF);
    check("collision_held_idle", Collision, 1);
    rd(8'h02, 8'hFF);
    ClearReq = 1'b1;
    DataAddress = 8'h04;
    DataIn = 8'h77;
    WriteMem = 1'b1;
    cyc();
    ClearReq = 1'b0;
    WriteMem = 1'b0;
    check("collision_cleared", Collision, 0);
    wait_idle(n, quiet, coll_low);
    check("clear_len_req_write", n, 256);
    for (int i = 0; i < 5; i++) rd(8'(i), 8'h00);
    check("collision_after_clear", Collision, 0);

    // reset in the middle of a clear
    wr(8'hF0, 8'hC3);
    wr(8'h63, 8'h9A);
    rd(8'hF0, 8'hC3);
    ClearReq = 1'b1;
    cyc();
    ClearReq = 1'b0;
    repeat (100) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("midreset_busy", Busy, 1);
    wait_idle(n, quiet, coll_low);
    check("clear_len_mid_reset", n, 256);
    rd(8'h00, 8'h00);
    rd(8'h63, 8'h00);
    rd(8'h64, 8'h00);
    rd(8'hF0, 8'h00);
    rd(8'hFF, 8'h00);

    cyc();
    cyc();
    check("scoreboard_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_seq.md
# data_mem_seq

Parametrised successor to the team's single-port data memory. Adds configurable data and address widths, a registered read port with a valid strobe, write-first read-during-write forwarding, and a hardware clear sequencer that runs after reset or on request. It sits between the processor's load/store unit and the memory core. The core stalls on `Busy` and does not rely on a tristated read bus.

## Interface
- `DW`, 8: data word width in bits.
- `AW`, 8: address width; depth is `DEPTH = 2**AW` words.
- `CLEAR_VAL`, 0: `DW`-bit value written to every word by the clear sequencer.

- `CLK`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `CLK` rising edge; 0 = reset.
- `DataAddress`  in  `AW`  word pointer for both read and write.
- `ReadMem`  in  1  read request, sampled each edge.
- `WriteMem`  in  1  write request, sampled each edge.
- `DataIn`  in  `DW`  write data.
- `ClearReq`  in  1  single-cycle request to re-run the clear sequence.
- `DataOut`  out  `DW`  registered read data; holds its last value between reads.
- `ReadValid`  out  1  high for exactly one cycle after each accepted read.
- `Busy`  out  1  high while the clear sequencer owns the array.
- `Collision`  out  1  sticky flag: a read or write was attempted while `Busy`.

## Operation
- **Storage:** `DEPTH` × `DW` array, no byte enables. Contents are undefined until the first clear completes.
- **FSM states:** CLEAR and IDLE. `Busy = (state == CLEAR)`, decoded combinationally from state.
- **Reset (`reset` = 0 at an edge):**
  - state ← CLEAR, clear pointer ← 0.
  - `DataOut` ← 0, `ReadValid` ← 0, `Collision` ← 0.
  - The array is not written while reset is held.
- **CLEAR state:**
  - Each edge with `reset` = 1 writes `core[ptr] ← CLEAR_VAL` and increments `ptr`.
  - On the edge that writes `ptr == DEPTH-1`, state ← IDLE and `ptr` wraps to 0.
- **IDLE state, accepted read (`ReadMem` = 1):**
  - `DataOut` ← `core[DataAddress]` and `ReadValid` ← 1.
  - If `WriteMem` = 1 in the same cycle, `DataOut` ← `DataIn` (write-first forwarding). The address is shared, so forwarding always applies.
- **IDLE state, accepted write (`WriteMem` = 1):** `core[DataAddress]` ← `DataIn`.
- **No read in a cycle:** `ReadValid` ← 0 and `DataOut` holds its value.
- **`ClearReq` = 1 in IDLE:**
  - state ← CLEAR, `ptr` ← 0, `Collision` ← 0.
  - Any same-cycle write is dropped.
  - Any same-cycle read still completes from the old contents, with `ReadValid` = 1 the next cycle.
- **`ClearReq` in CLEAR:** ignored; the sequence is not restarted.
- **`ReadMem` or `WriteMem` while `Busy`:** the request is ignored, no array change and `ReadValid` stays 0; `Collision` ← 1.
- **`Collision`:** clears only on reset or an accepted `ClearReq`.
- **Reset mid-clear:** sequencer restarts at address 0; a full `DEPTH` walk follows.

## Timing
- Read latency is 1 cycle: address and `ReadMem` at edge N, data and `ReadValid` visible after edge N.
- Write latency is 1 cycle: a read at edge N+1 of an address written at edge N returns the new data.
- Clear duration is exactly `DEPTH` cycles:
  - `Busy` goes high after the first edge with `reset` = 0, or after an accepted `ClearReq` edge.
  - `Busy` falls after the `DEPTH`-th edge with `reset` = 1 in CLEAR.
- Requests on the cycle `Busy` first reads 0 are accepted.
- Back-to-back reads give `ReadValid` high on consecutive cycles; there is no throughput penalty.

## Test plan
- **Reset and clear timing:** hold `reset` = 0 for 3 edges, then release. Required:
  - `Busy` = 1 for exactly 256 cycles.
  - `DataOut` = 0 and `ReadValid` = 0 throughout.
  - Reads of addresses 0x00, 0x7F and 0xFF afterwards return 0x00.
- **Basic write/read:** write 0xA5 to 0x10, then read 0x10 on the next cycle. Required: `DataOut` = 0xA5 and `ReadValid` = 1 one cycle later, then `ReadValid` = 0.
- **Read-during-write:** address 0x20 holds 0x11; assert read and write of 0x3C to 0x20 in the same cycle. Required: `DataOut` = 0x3C and the array holds 0x3C.
- **Access while busy:** assert `WriteMem` (0x55 to 0x05) 10 cycles into a clear. Required:
  - `Collision` = 1 and stays high until the next accepted `ClearReq`.
  - 0x05 reads 0x00 after the clear completes.
  - No `ReadValid` during `Busy`.
- **ClearReq with write:** fill 0x00–0x03 with 0xFF, then pulse `ClearReq` together with a write of 0x77 to 0x04. Required: after 256 cycles, 0x00–0x04 all read 0x00 and `Collision` = 0.
- **Reset mid-clear:** assert `reset` = 0 at clear cycle 100, then release. Required: `Busy` stays high for a further full 256 cycles from release, and all words read 0x00.
